// File: rtl/multimode_flip_flop_bank.sv
// Purpose : bank of WIDTH flip-flops sharing one mode (SR/JK/D/T), plus SR S=R=1 conflict tracking.
// Latency : one cycle from inputs to Q/conflict/conflict_cnt; Qbar is ~Q with no added delay.
// Backpres: none; en=0 freezes state, clr_conflict still acts while en=0.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset (Q=RESET_VAL, conflict and counter cleared)
//   en           update enable for Q and conflict tracking
//   mode         00 SR, 01 JK, 10 D, 11 T (same mode for every bit)
//   S, R         per-bit S/J/D/T and R/K inputs (R unused in D and T modes)
//   clr_conflict synchronous clear of conflict flag and counter
//   Q, Qbar      registered state and its exact complement
//   conflict     sticky flag: an SR-mode S=R=1 cycle has been seen
//   conflict_cnt saturating count of SR-mode conflict cycles
module multimode_flip_flop_bank #(
    parameter int                  WIDTH       = 4,
    parameter logic [WIDTH-1:0]    RESET_VAL   = '0,
    parameter int                  SR_PRIORITY = 0,
    parameter int                  CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             clr_conflict,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_next;
    logic             conflict_event;
    logic [CNT_W-1:0] cnt_inc;

    // Per-bit next-state; mode is decoded fresh every cycle, so there is no mode state.
    always_comb begin
        q_next = Q;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (mode)
                MODE_SR: begin
                    unique case ({S[i], R[i]})
                        2'b10:   q_next[i] = 1'b1;
                        2'b01:   q_next[i] = 1'b0;
                        2'b11: begin
                            if (SR_PRIORITY == 1)      q_next[i] = 1'b1;
                            else if (SR_PRIORITY == 2) q_next[i] = 1'b0;
                            else                       q_next[i] = Q[i];
                        end
                        default: q_next[i] = Q[i];
                    endcase
                end
                MODE_JK: begin
                    unique case ({S[i], R[i]})
                        2'b10:   q_next[i] = 1'b1;
                        2'b01:   q_next[i] = 1'b0;
                        2'b11:   q_next[i] = ~Q[i];
                        default: q_next[i] = Q[i];
                    endcase
                end
                MODE_D:  q_next[i] = S[i];
                MODE_T:  q_next[i] = S[i] ? ~Q[i] : Q[i];
                default: q_next[i] = Q[i];
            endcase
        end
    end

    // One event per cycle no matter how many bits collide; the SR_PRIORITY
    // policy only decides the resulting Q, never whether this fires.
    assign conflict_event = en && (mode == MODE_SR) && (|(S & R));
    assign cnt_inc        = (conflict_cnt == CNT_MAX) ? conflict_cnt
                                                      : conflict_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            Q            <= RESET_VAL;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            if (en) begin
                Q <= q_next;
            end
            // An event in the same cycle as a clear restarts the count at one.
            if (conflict_event) begin
                conflict     <= 1'b1;
                conflict_cnt <= clr_conflict ? CNT_W'(1) : cnt_inc;
            end else if (clr_conflict) begin
                conflict     <= 1'b0;
                conflict_cnt <= '0;
            end
        end
    end

    // Derived from the register, so it tracks Q exactly, reset included.
    assign Qbar = ~Q;

endmodule
